// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Shares the single register-file write port between two
//            write-back requesters (A = ALU, B = load). Each requester owns a
//            2-entry FIFO; a round-robin arbiter drains one write per cycle
//            into a registered one-hot load-enable vector and write-data bus.
//            Writes to r0 are consumed without asserting any load enable.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 2
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic [NUM_REGS-1:0] LE,
    output logic [DATA_W-1:0]   WD,
    output logic                wr_src,
    output logic                busy
);

    // FIFO occupancy limit; the counters are 2 bits wide and cover 0..2.
    localparam logic [1:0] c_full = 2'(DEPTH);

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]        w_valid;
    logic [1:0]        w_ready;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_nonempty;
    logic [ADDR_W-1:0] w_in_addr   [0:1];
    logic [DATA_W-1:0] w_in_data   [0:1];
    logic [ADDR_W-1:0] w_head_addr [0:1];
    logic [DATA_W-1:0] w_head_data [0:1];

    logic              w_grant_a;
    logic              w_grant_b;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NUM_REGS-1:0] w_le_next;

    logic                r_rr;     // 0: A preferred next, 1: B preferred next
    logic [NUM_REGS-1:0] r_le;
    logic [DATA_W-1:0]   r_wd;
    logic                r_src;

    assign w_valid      = {b_valid, a_valid};
    assign w_in_addr[0] = a_addr;
    assign w_in_addr[1] = b_addr;
    assign w_in_data[0] = a_data;
    assign w_in_data[1] = b_data;

    assign a_ready = w_ready[0];
    assign b_ready = w_ready[1];

    // ------------------------------------------------------------------------
    // Per-requester 2-entry FIFOs. Ready depends only on the stored count, so
    // a full FIFO refuses a push even when it pops on the same edge, and a new
    // entry always spends one edge in storage before it can be granted.
    // ------------------------------------------------------------------------
    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic [1:0]        r_cnt;
        logic              r_wptr;
        logic              r_rptr;
        logic [ADDR_W-1:0] r_addr_mem [0:1];
        logic [DATA_W-1:0] r_data_mem [0:1];

        assign w_ready[s]     = Clr & (r_cnt < c_full);
        assign w_push[s]      = w_valid[s] & w_ready[s];
        assign w_nonempty[s]  = (r_cnt != 2'd0);
        assign w_head_addr[s] = r_addr_mem[r_rptr];
        assign w_head_data[s] = r_data_mem[r_rptr];

        // Entry storage; contents are meaningless while the count is zero.
        always_ff @(posedge Clk) begin
            if (w_push[s]) begin
                r_addr_mem[r_wptr] <= w_in_addr[s];
                r_data_mem[r_wptr] <= w_in_data[s];
            end
        end

        // Pointers and occupancy; push and pop together leave the count alone.
        always_ff @(posedge Clk or negedge Clr) begin
            if (!Clr) begin
                r_cnt  <= 2'd0;
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_push[s]) begin
                    r_wptr <= ~r_wptr;
                end
                if (w_pop[s]) begin
                    r_rptr <= ~r_rptr;
                end
                case ({w_push[s], w_pop[s]})
                    2'b10:   r_cnt <= r_cnt + 2'd1;
                    2'b01:   r_cnt <= r_cnt - 2'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Round-robin grant over heads that were already stored before this edge.
    always_comb begin
        w_grant_a  = w_nonempty[0] & (~w_nonempty[1] | ~r_rr);
        w_grant_b  = w_nonempty[1] & (~w_nonempty[0] |  r_rr);
        w_pop      = {w_grant_b, w_grant_a};
        w_sel_addr = w_grant_b ? w_head_addr[1] : w_head_addr[0];
        w_sel_data = w_grant_b ? w_head_data[1] : w_head_data[0];
        w_le_next  = '0;
        if (w_sel_addr != '0) begin
            w_le_next = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_sel_addr;
        end
    end

    // Registered write port: LE pulses for one cycle per grant (never for r0),
    // WD/wr_src hold their last value while idle, and rr flips after any grant.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_rr  <= 1'b0;
            r_le  <= '0;
            r_wd  <= '0;
            r_src <= 1'b0;
        end else if (w_grant_a | w_grant_b) begin
            r_rr  <= w_grant_a;
            r_le  <= w_le_next;
            r_wd  <= w_sel_data;
            r_src <= w_grant_b;
        end else begin
            r_le  <= '0;
        end
    end

    assign LE     = r_le;
    assign WD     = r_wd;
    assign wr_src = r_src;
    assign busy   = (|w_nonempty) | (|r_le);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed scoreboard bench for regfile_write_arbiter. Expected
//            write-port activity is queued with its due cycle when stimulus is
//            driven and compared every cycle once the DUT reaches that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] LE;
    logic [31:0] WD;
    logic        wr_src;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [31:0] le;
        logic [31:0] wd;
        logic        src;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] rf [32];

    regfile_write_arbiter dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .LE      (LE),
        .WD      (WD),
        .wr_src  (wr_src),
        .busy    (busy)
    );

    always #5 Clk = ~Clk;

    // Edge counter: after edge n (sampled #1 later) cyc reads n.
    always @(posedge Clk) cyc <= cyc + 1;

    // Register file behind the write port.
    always @(posedge Clk) begin
        for (int i = 0; i < 32; i++) begin
            if (LE[i]) rf[i] <= WD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Queue the write-port state expected right after edge 'at'.
    task automatic expect_wr(input int at, input int addr, input logic [31:0] d, input logic s);
        exp_t e;
        e.cyc = at;
        e.le  = (addr == 0) ? 32'd0 : (32'd1 << addr);
        e.wd  = d;
        e.src = s;
        sb.push_back(e);
    endtask

    // Advance one edge and compare the write port against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        chk("le_onehot0", 32'($onehot0(LE)), 32'd1);
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("le", LE, e.le);
            chk("wd", WD, e.wd);
            chk("wr_src", 32'(wr_src), 32'(e.src));
        end else begin
            chk("idle_le", LE, 32'd0);
        end
    endtask

    task automatic do_reset();
        Clr = 1'b0;
        #1;
        chk("rst_le", LE, 32'd0);
        @(posedge Clk);
        #1;
        Clr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr     = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'h0;
        b_valid = 1'b0;
        b_addr  = 5'd0;
        b_data  = 32'h0;

        // Reset held with A requesting.
        #2;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_LE", LE, 32'd0);
        chk("rst_WD", WD, 32'd0);
        chk("rst_src", 32'(wr_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge Clk);
        #1;
        chk("rst_edge_a_ready", 32'(a_ready), 32'd0);
        chk("rst_edge_LE", LE, 32'd0);
        a_valid = 1'b0;
        Clr     = 1'b1;
        #1;
        chk("rel_a_ready", 32'(a_ready), 32'd1);
        chk("rel_b_ready", 32'(b_ready), 32'd1);

        // Single uncontended write.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        expect_wr(cyc + 2, 5, 32'hDEADBEEF, 1'b0);
        step();
        a_valid = 1'b0;
        step();
        chk("single_busy", 32'(busy), 32'd1);
        step();
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Same-address contention right after reset: A then B, B wins.
        do_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11111111;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h22222222;
        expect_wr(cyc + 2, 3, 32'h11111111, 1'b0);
        expect_wr(cyc + 3, 3, 32'h22222222, 1'b1);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        step();
        step();
        chk("contention_r3", rf[3], 32'h22222222);

        // Backpressure on B while A keeps competing.
        chk("bp_a_ready0", 32'(a_ready), 32'd1);
        chk("bp_b_ready0", 32'(b_ready), 32'd1);
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0000001;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB0000001;
        expect_wr(cyc + 2, 10, 32'hA0000001, 1'b0);
        expect_wr(cyc + 3, 11, 32'hB0000001, 1'b1);
        step();
        a_data = 32'hA0000002;
        b_data = 32'hB0000002;
        expect_wr(cyc + 3, 10, 32'hA0000002, 1'b0);
        expect_wr(cyc + 4, 11, 32'hB0000002, 1'b1);
        step();
        chk("bp_b_full", 32'(b_ready), 32'd0);
        chk("bp_a_open", 32'(a_ready), 32'd1);
        a_data = 32'hA0000003;
        b_data = 32'hB0000003;
        expect_wr(cyc + 4, 10, 32'hA0000003, 1'b0);
        step();
        chk("bp_b_reopen", 32'(b_ready), 32'd1);
        chk("bp_a_full", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        expect_wr(cyc + 4, 11, 32'hB0000003, 1'b1);
        step();
        b_valid = 1'b0;
        step();
        step();
        step();
        step();
        chk("bp_drained_busy", 32'(busy), 32'd0);

        // r0 write is consumed without a load enable.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hCAFEBABE;
        expect_wr(cyc + 2, 0, 32'hCAFEBABE, 1'b0);
        step();
        a_valid = 1'b0;
        step();
        chk("r0_popped_busy", 32'(busy), 32'd0);
        chk("r0_a_ready", 32'(a_ready), 32'd1);
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h12345678;
        expect_wr(cyc + 2, 1, 32'h12345678, 1'b0);
        step();
        a_valid = 1'b0;
        step();
        step();
        chk("r1_value", rf[1], 32'h12345678);

        // Mid-operation reset discards everything in flight.
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hA5000001;
        b_valid = 1'b1; b_addr = 5'd14; b_data = 32'hB5000001;
        step();
        a_addr = 5'd13; a_data = 32'hA5000002;
        b_addr = 5'd15; b_data = 32'hB5000002;
        expect_wr(cyc + 1, 14, 32'hB5000001, 1'b1);
        step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        a_valid = 1'b0; b_valid = 1'b0;
        Clr = 1'b0;
        #1;
        chk("mid_LE", LE, 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_a_ready", 32'(a_ready), 32'd0);
        chk("mid_b_ready", 32'(b_ready), 32'd0);
        chk("mid_WD", WD, 32'd0);
        #2;
        Clr = 1'b1;
        sb.delete();
        #1;
        chk("mid_rel_a_ready", 32'(a_ready), 32'd1);
        step();
        chk("post_busy1", 32'(busy), 32'd0);
        step();
        chk("post_busy2", 32'(busy), 32'd0);
        step();
        chk("post_busy3", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
